// File: rtl/unidade_controle.sv
// unidade_controle: Moore control FSM sequencing fetch/decode/execute for the 8-bit processor.
// Optional macro EXT_BRANCH_EN adds the BMI/BPL/BVS/BVC/BCS/BCC conditional branches.
module unidade_controle (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] IR,
  input  logic [3:0] CCR_Result,
  output logic       IR_Load,
  output logic       MAR_Load,
  output logic       PC_Load,
  output logic       PC_Inc,
  output logic       A_Load,
  output logic       B_Load,
  output logic       CCR_Load,
  output logic [1:0] Bus1_Sel,
  output logic [1:0] Bus2_Sel,
  output logic [2:0] ALU_Sel,
  output logic       write
);

  localparam logic [7:0] LDA_IMM = 8'h86;
  localparam logic [7:0] LDA_DIR = 8'h87;
  localparam logic [7:0] LDB_IMM = 8'h88;
  localparam logic [7:0] LDB_DIR = 8'h89;
  localparam logic [7:0] STA_DIR = 8'h96;
  localparam logic [7:0] STB_DIR = 8'h97;
  localparam logic [7:0] ADD_AB  = 8'h42;
  localparam logic [7:0] SUB_AB  = 8'h43;
  localparam logic [7:0] AND_AB  = 8'h44;
  localparam logic [7:0] OR_AB   = 8'h45;
  localparam logic [7:0] BRA     = 8'h20;
  localparam logic [7:0] BEQ     = 8'h23;
  localparam logic [7:0] BNE     = 8'h24;
`ifdef EXT_BRANCH_EN
  localparam logic [7:0] BMI     = 8'h21;
  localparam logic [7:0] BPL     = 8'h22;
  localparam logic [7:0] BVS     = 8'h25;
  localparam logic [7:0] BVC     = 8'h26;
  localparam logic [7:0] BCS     = 8'h27;
  localparam logic [7:0] BCC     = 8'h28;
`endif

  localparam logic [1:0] BUS1_PC   = 2'b00;
  localparam logic [1:0] BUS1_A    = 2'b01;
  localparam logic [1:0] BUS1_B    = 2'b10;
  localparam logic [1:0] BUS2_ALU  = 2'b00;
  localparam logic [1:0] BUS2_BUS1 = 2'b01;
  localparam logic [1:0] BUS2_MEM  = 2'b10;
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;

  typedef enum logic [5:0] {
    S_FETCH_0, S_FETCH_1, S_FETCH_2, S_DECODE_3,
    S_LDA_IMM_4, S_LDA_IMM_5, S_LDA_IMM_6,
    S_LDA_DIR_4, S_LDA_DIR_5, S_LDA_DIR_6, S_LDA_DIR_7, S_LDA_DIR_8,
    S_LDB_IMM_4, S_LDB_IMM_5, S_LDB_IMM_6,
    S_LDB_DIR_4, S_LDB_DIR_5, S_LDB_DIR_6, S_LDB_DIR_7, S_LDB_DIR_8,
    S_STA_DIR_4, S_STA_DIR_5, S_STA_DIR_6, S_STA_DIR_7,
    S_STB_DIR_4, S_STB_DIR_5, S_STB_DIR_6, S_STB_DIR_7,
    S_ADD_AB_4, S_SUB_AB_4, S_AND_AB_4, S_OR_AB_4,
    S_BR_4, S_BR_5, S_BR_6, S_BRN_5
  } state_t;

  state_t     state, next_state;
  logic       is_branch, always_taken, flag_pol, take_branch, br_taken;
  logic [1:0] flag_idx;

  // Each branch opcode selects one flag and a polarity; BRA ignores the flags.
  always_comb begin
    is_branch    = 1'b0;
    always_taken = 1'b0;
    flag_idx     = 2'd2;
    flag_pol     = 1'b0;
    case (IR)
      BRA: begin is_branch = 1'b1; always_taken = 1'b1; end
      BEQ: begin is_branch = 1'b1; flag_idx = 2'd2; end
      BNE: begin is_branch = 1'b1; flag_idx = 2'd2; flag_pol = 1'b1; end
`ifdef EXT_BRANCH_EN
      BMI: begin is_branch = 1'b1; flag_idx = 2'd3; end
      BPL: begin is_branch = 1'b1; flag_idx = 2'd3; flag_pol = 1'b1; end
      BVS: begin is_branch = 1'b1; flag_idx = 2'd1; end
      BVC: begin is_branch = 1'b1; flag_idx = 2'd1; flag_pol = 1'b1; end
      BCS: begin is_branch = 1'b1; flag_idx = 2'd0; end
      BCC: begin is_branch = 1'b1; flag_idx = 2'd0; flag_pol = 1'b1; end
`endif
      default: ;
    endcase
  end

  assign take_branch = always_taken | (CCR_Result[flag_idx] ^ flag_pol);

  // The branch decision is frozen in decode so S_BR_4 knows which tail to take.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= S_FETCH_0;
      br_taken <= 1'b0;
    end else begin
      state <= next_state;
      if (state == S_DECODE_3)
        br_taken <= take_branch;
    end
  end

  always_comb begin
    next_state = S_FETCH_0;
    IR_Load    = 1'b0;
    MAR_Load   = 1'b0;
    PC_Load    = 1'b0;
    PC_Inc     = 1'b0;
    A_Load     = 1'b0;
    B_Load     = 1'b0;
    CCR_Load   = 1'b0;
    Bus1_Sel   = BUS1_PC;
    Bus2_Sel   = BUS2_ALU;
    ALU_Sel    = ALU_ADD;
    write      = 1'b0;
    if (reset) begin
      case (state)
        S_FETCH_0: begin
          Bus1_Sel = BUS1_PC; Bus2_Sel = BUS2_BUS1; MAR_Load = 1'b1;
          next_state = S_FETCH_1;
        end
        S_FETCH_1: begin PC_Inc = 1'b1; next_state = S_FETCH_2; end
        S_FETCH_2: begin
          Bus2_Sel = BUS2_MEM; IR_Load = 1'b1;
          next_state = S_DECODE_3;
        end
        S_DECODE_3: begin
          case (IR)
            LDA_IMM: next_state = S_LDA_IMM_4;
            LDA_DIR: next_state = S_LDA_DIR_4;
            LDB_IMM: next_state = S_LDB_IMM_4;
            LDB_DIR: next_state = S_LDB_DIR_4;
            STA_DIR: next_state = S_STA_DIR_4;
            STB_DIR: next_state = S_STB_DIR_4;
            ADD_AB:  next_state = S_ADD_AB_4;
            SUB_AB:  next_state = S_SUB_AB_4;
            AND_AB:  next_state = S_AND_AB_4;
            OR_AB:   next_state = S_OR_AB_4;
            default: next_state = is_branch ? S_BR_4 : S_FETCH_0;
          endcase
        end
        S_LDA_IMM_4, S_LDA_DIR_4, S_LDB_IMM_4, S_LDB_DIR_4,
        S_STA_DIR_4, S_STB_DIR_4, S_BR_4: begin
          Bus1_Sel = BUS1_PC; Bus2_Sel = BUS2_BUS1; MAR_Load = 1'b1;
          case (state)
            S_LDA_IMM_4: next_state = S_LDA_IMM_5;
            S_LDA_DIR_4: next_state = S_LDA_DIR_5;
            S_LDB_IMM_4: next_state = S_LDB_IMM_5;
            S_LDB_DIR_4: next_state = S_LDB_DIR_5;
            S_STA_DIR_4: next_state = S_STA_DIR_5;
            S_STB_DIR_4: next_state = S_STB_DIR_5;
            default:     next_state = br_taken ? S_BR_5 : S_BRN_5;
          endcase
        end
        S_LDA_IMM_5: begin PC_Inc = 1'b1; next_state = S_LDA_IMM_6; end
        S_LDA_DIR_5: begin PC_Inc = 1'b1; next_state = S_LDA_DIR_6; end
        S_LDB_IMM_5: begin PC_Inc = 1'b1; next_state = S_LDB_IMM_6; end
        S_LDB_DIR_5: begin PC_Inc = 1'b1; next_state = S_LDB_DIR_6; end
        S_STA_DIR_5: begin PC_Inc = 1'b1; next_state = S_STA_DIR_6; end
        S_STB_DIR_5: begin PC_Inc = 1'b1; next_state = S_STB_DIR_6; end
        S_BRN_5:     begin PC_Inc = 1'b1; next_state = S_FETCH_0;   end
        S_LDA_IMM_6: begin Bus2_Sel = BUS2_MEM; A_Load = 1'b1; end
        S_LDB_IMM_6: begin Bus2_Sel = BUS2_MEM; B_Load = 1'b1; end
        S_LDA_DIR_6: begin Bus2_Sel = BUS2_MEM; MAR_Load = 1'b1; next_state = S_LDA_DIR_7; end
        S_LDB_DIR_6: begin Bus2_Sel = BUS2_MEM; MAR_Load = 1'b1; next_state = S_LDB_DIR_7; end
        S_STA_DIR_6: begin Bus2_Sel = BUS2_MEM; MAR_Load = 1'b1; next_state = S_STA_DIR_7; end
        S_STB_DIR_6: begin Bus2_Sel = BUS2_MEM; MAR_Load = 1'b1; next_state = S_STB_DIR_7; end
        S_LDA_DIR_7: next_state = S_LDA_DIR_8;
        S_LDB_DIR_7: next_state = S_LDB_DIR_8;
        S_LDA_DIR_8: begin Bus2_Sel = BUS2_MEM; A_Load = 1'b1; end
        S_LDB_DIR_8: begin Bus2_Sel = BUS2_MEM; B_Load = 1'b1; end
        S_STA_DIR_7: begin Bus1_Sel = BUS1_A; write = 1'b1; end
        S_STB_DIR_7: begin Bus1_Sel = BUS1_B; write = 1'b1; end
        S_ADD_AB_4, S_SUB_AB_4, S_AND_AB_4, S_OR_AB_4: begin
          Bus1_Sel = BUS1_B; Bus2_Sel = BUS2_ALU; A_Load = 1'b1; CCR_Load = 1'b1;
          case (state)
            S_SUB_AB_4: ALU_Sel = ALU_SUB;
            S_AND_AB_4: ALU_Sel = ALU_AND;
            S_OR_AB_4:  ALU_Sel = ALU_OR;
            default:    ALU_Sel = ALU_ADD;
          endcase
        end
        S_BR_5: next_state = S_BR_6;
        S_BR_6: begin Bus2_Sel = BUS2_MEM; PC_Load = 1'b1; end
        default: next_state = S_FETCH_0;
      endcase
    end
  end

endmodule
